spi_slave_fifo: RTL
===================

# spi_slave_fifo

Parametrised SPI slave receiver/transmitter running entirely in the system clock domain. Oversamples `sck`, `mosi` and `ss` through synchronisers and supports all four SPI modes. Received words go into a FIFO read through a valid/ready handshake, and each received word simultaneously shifts a response word out on `miso`. It is the front end between the external game controller (SPI master) and the move-decoding logic, with overflow and framing error reporting.

## Interface
- `DATA_W`, 8: bits per SPI word (≥2).
- `DEPTH`, 4: receive FIFO entries (power of two, ≥2).
- `CPOL`, 0: `sck` idle level.
- `CPHA`, 0: 0 = sample on leading edge, shift on trailing; 1 = shift on leading, sample on trailing.
- `MSB_FIRST`, 1: 1 = MSB first on both `mosi` and `miso`; 0 = LSB first.

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `sck` in 1: SPI clock from the master; asynchronous to `clk`.
- `mosi` in 1: master-out data; asynchronous.
- `ss` in 1: slave select, active low; asynchronous.
- `miso` out 1: slave-out data. Driven 0 while the synchronised `ss` is high.
- `tx_data` in DATA_W: response word, loaded at each word start.
- `rx_data` out DATA_W: FIFO head; valid only while `rx_valid`=1.
- `rx_valid` out 1: FIFO not empty.
- `rx_ready` in 1: consumer pops the head when `rx_valid & rx_ready`.
- `rx_count` out $clog2(DEPTH+1): current FIFO occupancy, 0..DEPTH.
- `overflow` out 1: sticky; a completed word was dropped because the FIFO was full.
- `frame_err` out 1: sticky; `ss` deasserted mid-word.
- `clr_err` in 1: one-cycle pulse clears both sticky flags.

## Operation
- `sck`, `mosi` and `ss` each pass through a 2-FF synchroniser. A third register on `sck` and `ss` provides edge detection.
- Leading edge = `sck` transition from CPOL to !CPOL. Trailing edge = the reverse.
- FSM states:
  - IDLE: synchronised `ss` is high.
  - ACTIVE: `ss` is low.
- IDLE→ACTIVE on `ss` fall:
  - `bit_cnt` cleared.
  - TX shift register loaded from `tx_data`.
  - `miso` presents the first TX bit.
- Sample edge:
  - `mosi` shifted into the RX shift register.
  - `bit_cnt` incremented.
- Shift edge: the TX register advances and `miso` shows the next bit.
  - CPHA=1 exception: the first leading edge of a word does not advance the register, because bit 0 is already presented.
- Word complete when sample number DATA_W is captured:
  - Word pushed to the FIFO.
  - `bit_cnt` wraps to 0.
  - TX register reloaded from `tx_data`.
  - FSM stays in ACTIVE; back-to-back words under one `ss` assertion are supported.
- Bit ordering follows MSB_FIRST: assembled word is bit-exact to master transmit order.
- ACTIVE→IDLE on `ss` rise:
  - If `bit_cnt`≠0, the partial word is discarded and `frame_err` is set.
  - If `bit_cnt`=0, no error.
- FIFO push when full:
  - Word dropped and `overflow` set.
  - Exception: if a pop occurs in the same cycle, the push is accepted and occupancy is unchanged.
- Simultaneous push and pop when not full: occupancy unchanged. Push and pop when empty: push only (no data to pop).
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from `rx_count`.
- `clr_err` asserted in the same cycle a new error is detected: the flag ends set (error wins).
- Reset (`rst`=0), any time including mid-word:
  - FSM to IDLE; FIFO emptied.
  - `rx_valid`=0, `rx_count`=0, `rx_data`=0, `miso`=0, `overflow`=0, `frame_err`=0.
  - Synchronisers cleared: `ss` to 1, `sck` to CPOL.

## Timing
- Pin-to-action latency: an `sck`/`ss` transition is acted on at the 3rd `clk` rising edge after it meets setup.
- Master constraints, in `clk` periods:
  - `sck` high ≥4 and low ≥4.
  - `ss` fall to first `sck` edge ≥4.
  - Last `sck` edge to `ss` rise ≥4.
- `miso` updates 3 clk after the shift edge (or `ss` fall); the master must sample no earlier than its next edge.
- Final bit captured at clk edge T → FIFO write, `rx_valid`=1 and updated `rx_count` visible after edge T+1.
- Pop at edge P (`rx_valid & rx_ready`) → next head or `rx_valid`=0 after edge P.
- Sticky flags set at the edge detecting the condition; cleared at the edge after a `clr_err` pulse.

## Test plan
- **Mode 0, DATA_W=8:** send 0xA5 with `tx_data`=0x3C, `rx_ready`=1 → `rx_data`=0xA5 for one cycle with `rx_valid`, master receives 0x3C on `miso`.
- **All four modes, MSB_FIRST=0:** send 0x01 in each mode → `rx_data`=0x01 and `miso` word equals `tx_data` in every mode.
- **Burst, DEPTH=4, `rx_ready`=0:** 5 words 0x11..0x55 under one `ss` assertion → `rx_count`=4, `overflow`=1, FIFO drains 0x11,0x22,0x33,0x44.
- **Framing error:** `ss` rises after 5 bits → `frame_err`=1, `rx_count` unchanged. Next full word 0x7E is received correctly. `clr_err` clears the flag.
- **Full FIFO with simultaneous pop and push:** `rx_count` stays 4, `overflow` stays 0, order is preserved.
- **Reset mid-word after 3 bits:** all outputs return to reset values. The next complete word is received intact.

Source files
------------

// File: rtl/spi_slave_fifo.sv
// rtl/spi_slave_fifo.sv - SPI slave (all four modes) with synchronised inputs and a receive FIFO
module spi_slave_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sck,
    input  logic                       mosi,
    input  logic                       ss,
    output logic                       miso,
    input  logic [DATA_W-1:0]          tx_data,
    output logic [DATA_W-1:0]          rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic [$clog2(DEPTH+1)-1:0] rx_count,
    output logic                       overflow,
    output logic                       frame_err,
    input  logic                       clr_err
);
    localparam int   CNT_W    = $clog2(DATA_W);
    localparam int   PTR_W    = $clog2(DEPTH);
    localparam int   OCC_W    = $clog2(DEPTH + 1);
    localparam logic SCK_IDLE = (CPOL != 0);

    logic sck_s1, sck_s2, sck_s3;
    logic ss_s1, ss_s2, ss_s3;
    logic mosi_s1, mosi_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {sck_s1, sck_s2, sck_s3} <= {3{SCK_IDLE}};
            {ss_s1, ss_s2, ss_s3}    <= 3'b111;
            {mosi_s1, mosi_s2}       <= 2'b00;
        end else begin
            {sck_s1, sck_s2, sck_s3} <= {sck, sck_s1, sck_s2};
            {ss_s1, ss_s2, ss_s3}    <= {ss, ss_s1, ss_s2};
            {mosi_s1, mosi_s2}       <= {mosi, mosi_s1};
        end
    end

    logic sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic ss_fall, ss_rise;

    assign sck_rise    = sck_s2 & ~sck_s3;
    assign sck_fall    = ~sck_s2 & sck_s3;
    assign lead_edge   = SCK_IDLE ? sck_fall : sck_rise;
    assign trail_edge  = SCK_IDLE ? sck_rise : sck_fall;
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
    assign ss_fall     = ~ss_s2 & ss_s3;
    assign ss_rise     = ss_s2 & ~ss_s3;

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_nxt;
    logic   load, do_sample, do_shift, abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = ACTIVE;
            ACTIVE:  if (ss_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load      = 1'b0;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE:   load = ss_fall;
            ACTIVE: begin
                abort     = ss_rise;
                do_sample = sample_edge & ~ss_rise;
                do_shift  = shift_edge & ~ss_rise;
            end
            default: ;
        endcase
    end

    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_shift, rx_next, tx_shift, tx_next;
    logic              skip, push, word_last;

    assign rx_next   = (MSB_FIRST != 0) ? {rx_shift[DATA_W-2:0], mosi_s2} : {mosi_s2, rx_shift[DATA_W-1:1]};
    assign tx_next   = (MSB_FIRST != 0) ? {tx_shift[DATA_W-2:0], 1'b0} : {1'b0, tx_shift[DATA_W-1:1]};
    assign word_last = (bit_cnt == CNT_W'(DATA_W - 1));

    // skip suppresses the first shift edge after a load: the reloaded bit 0 is already on miso
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            skip     <= 1'b0;
            push     <= 1'b0;
        end else begin
            push <= do_sample & word_last;
            if (load) begin
                bit_cnt  <= '0;
                tx_shift <= tx_data;
                skip     <= (CPHA != 0);
            end else if (abort) begin
                bit_cnt <= '0;
            end else if (do_sample) begin
                rx_shift <= rx_next;
                if (word_last) begin
                    bit_cnt  <= '0;
                    tx_shift <= tx_data;
                    skip     <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end else if (do_shift) begin
                if (skip) skip     <= 1'b0;
                else      tx_shift <= tx_next;
            end
        end
    end

    assign miso = (state == ACTIVE && !ss_s2) ? ((MSB_FIRST != 0) ? tx_shift[DATA_W-1] : tx_shift[0]) : 1'b0;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              full, pop, wr_en;

    assign rx_valid = (rx_count != '0);
    assign full     = (rx_count == OCC_W'(DEPTH));
    assign pop      = rx_valid & rx_ready;
    assign wr_en    = push & (~full | pop);
    assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rx_count  <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_en && !pop)      rx_count <= rx_count + OCC_W'(1);
            else if (pop && !wr_en) rx_count <= rx_count - OCC_W'(1);
            overflow  <= (push & full & ~pop) | (overflow & ~clr_err);
            frame_err <= (abort & (bit_cnt != '0)) | (frame_err & ~clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= rx_shift;
    end
endmodule
